// File: rtl/operand_sequencer_3x16.sv
// operand_sequencer_3x16: loads three operands from a valid/ready stream, then scans the mux selector 0..2.
module operand_sequencer_3x16 #(
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [1:0]        selector,
  output logic              mux_enable,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;
  state_t state, next;
  logic [1:0] word_cnt;
  logic [7:0] hold_cnt;
  logic accept, hold_end;
  assign accept   = state == LOAD && in_valid;
  assign hold_end = hold_cnt == 8'(HOLD_CYCLES - 1);
  always_comb begin
    next = state == IDLE ? (start ? LOAD : IDLE)
         : state == LOAD ? (accept && word_cnt == 2'd2 ? SCAN : LOAD)
         : state == SCAN ? (hold_end && selector == 2'd2 ? DONE : SCAN)
         : IDLE;
    in_ready   = state == LOAD;
    mux_enable = state == SCAN;
    busy       = state == LOAD || state == SCAN;
    done       = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      reg1     <= '0;
      reg2     <= '0;
      reg3     <= '0;
      word_cnt <= '0;
      hold_cnt <= '0;
      selector <= '0;
    end else begin
      state <= next;
      if (accept) begin
        word_cnt <= word_cnt == 2'd2 ? 2'd0 : word_cnt + 2'd1;
        if (word_cnt == 2'd0) reg1 <= in_data;
        if (word_cnt == 2'd1) reg2 <= in_data;
        if (word_cnt == 2'd2) reg3 <= in_data;
      end
      // selector wraps to 0 on leaving SCAN so it reads 0 everywhere else
      if (state == SCAN) begin
        hold_cnt <= hold_end ? 8'd0 : hold_cnt + 8'd1;
        if (hold_end) selector <= selector == 2'd2 ? 2'd0 : selector + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_operand_sequencer_3x16.sv
// tb_operand_sequencer_3x16: directed checks on HOLD_CYCLES=1 and HOLD_CYCLES=3 instances sharing stimulus.
module tb_operand_sequencer_3x16;
  logic clk = 0, reset, start, in_valid;
  logic [15:0] in_data;
  logic in_ready, mux_enable, busy, done, in_ready3, mux_enable3, busy3, done3;
  logic [15:0] reg1, reg2, reg3, reg1_3, reg2_3, reg3_3;
  logic [1:0] selector, selector3;
  int tests = 0, fails = 0, cyc = 0, t0;

  always #5 clk = ~clk;

  operand_sequencer_3x16 #(.DATA_W(16), .HOLD_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reg1(reg1), .reg2(reg2), .reg3(reg3), .selector(selector),
    .mux_enable(mux_enable), .busy(busy), .done(done));

  operand_sequencer_3x16 #(.DATA_W(16), .HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready3), .reg1(reg1_3), .reg2(reg2_3), .reg3(reg3_3), .selector(selector3),
    .mux_enable(mux_enable3), .busy(busy3), .done(done3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    start = 1; in_valid = 1; in_data = a;
    step();
    start = 0;
    step();
    in_data = b;
    step();
    in_data = c;
    step();
    in_valid = 0;
  endtask

  initial begin
    reset = 1; start = 0; in_valid = 0; in_data = '0;
    step(2);
    chk("reset_state", {in_ready, busy, mux_enable, done, selector, reg1, reg2, reg3}, 0);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_outputs", {in_ready, busy, mux_enable, done, selector, reg1, reg2, reg3}, 0);
    end

    // basic sequence, HOLD_CYCLES=1
    start = 1; in_valid = 1; in_data = 16'h1234; t0 = cyc;
    step();
    chk("load_entry", {in_ready, busy, mux_enable, reg1}, {3'b110, 16'h0000});
    start = 0;
    step();
    chk("reg1", reg1, 16'h1234);
    in_data = 16'hBEEF;
    step();
    chk("reg2", reg2, 16'hBEEF);
    in_data = 16'h00FF;
    step();
    chk("reg3", reg3, 16'h00FF);
    chk("scan_sel0", {in_ready, busy, mux_enable, selector}, 5'b01100);
    in_valid = 0;
    step();
    chk("scan_sel1", {mux_enable, selector, done}, 4'b1010);
    step();
    chk("scan_sel2", {mux_enable, selector, done}, 4'b1100);
    step();
    chk("done_pulse", {done, mux_enable, selector, busy}, 5'b10000);
    chk("latency", cyc - t0, 7);
    step();
    chk("done_one_cycle", {done, busy}, 2'b00);
    chk("regs_after", {reg1, reg2, reg3}, {16'h1234, 16'hBEEF, 16'h00FF});
    step(8);

    // stalled handshake between words 1 and 2
    start = 1; in_valid = 1; in_data = 16'h1111;
    step();
    start = 0;
    step();
    chk("stall_reg1", reg1, 16'h1111);
    in_valid = 0; in_data = 16'h9999;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_hold", {in_ready, reg2, reg3}, {1'b1, 16'hBEEF, 16'h00FF});
    end
    in_valid = 1; in_data = 16'h2222;
    step();
    chk("stall_reg2", {in_ready, reg2}, {1'b1, 16'h2222});
    in_data = 16'h3333;
    step();
    chk("stall_reg3", {in_ready, reg1, reg2, reg3}, {1'b0, 16'h1111, 16'h2222, 16'h3333});
    in_valid = 0;
    step(14);

    // hold timing, HOLD_CYCLES=3
    load(16'h00A1, 16'h00A2, 16'h00A3);
    chk("h3_regs", {reg1_3, reg2_3, reg3_3}, {16'h00A1, 16'h00A2, 16'h00A3});
    for (int i = 0; i < 9; i++) begin
      chk("h3_scan", {mux_enable3, done3, selector3}, {2'b10, 2'(i / 3)});
      step();
    end
    chk("h3_done", {done3, mux_enable3, selector3, busy3}, 5'b10000);
    step();
    chk("h3_done_end", {done3, busy3}, 2'b00);
    step(4);

    // reset during SCAN with selector=1
    load(16'h0A0A, 16'h0B0B, 16'h0C0C);
    step();
    chk("rst_pre", {mux_enable, selector}, 3'b101);
    reset = 1;
    step();
    reset = 0;
    chk("rst_mid", {mux_enable, selector, done, reg1, reg2, reg3}, 0);
    chk("rst_mid3", {mux_enable3, selector3, done3, reg1_3}, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_done", {done, busy, done3, busy3}, 0);
    end

    // ignored start during SCAN and in_valid during IDLE
    load(16'h5555, 16'h6666, 16'h7777);
    start = 1;
    step();
    start = 0;
    chk("ign_scan", {busy, mux_enable, selector}, 4'b1101);
    step(2);
    chk("ign_done", done, 1'b1);
    step();
    in_valid = 1; in_data = 16'hAAAA;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ign_idle", {busy, in_ready, reg1, reg2, reg3}, {2'b00, 16'h5555, 16'h6666, 16'h7777});
    end
    in_valid = 0;
    step(8);
    load(16'h0101, 16'h0202, 16'h0303);
    chk("reload", {mux_enable, reg1, reg2, reg3}, {1'b1, 16'h0101, 16'h0202, 16'h0303});
    step(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
